// File: rtl/la_seqen.sv
// Staged enable sequencer: ramps a thermometer-coded segment enable up one
// bit at a time (and back down in reverse), with a programmable dwell per step.
module la_seqen #(
  parameter int N    = 4,
  parameter int CW   = 8,
  parameter     PROP = "DEFAULT"
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          en,
  input  logic [CW-1:0] delay,
  output logic [N-1:0]  seg_en,
  output logic          on,
  output logic          off,
  output logic          busy
);

  typedef enum logic [1:0] {
    StOff,
    StUp,
    StOn,
    StDown
  } state_t;

  state_t        state_q, state_d;
  logic [N-1:0]  seg_en_q, seg_en_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          on_q, off_q, busy_q;

  logic atTop;
  logic atBottom;
  logic dwellDone;

  // The implementation property string carries no behaviour.
  if (PROP == "") begin : gPropEmpty
  end else begin : gPropSet
  end

  assign atTop     = &seg_en_q;
  assign atBottom  = ~|seg_en_q;
  assign dwellDone = (cnt_q == '0);

  // A step is only ever taken once the running dwell has expired, so a
  // direction change simply redirects the next step without restarting it.
  always_comb begin
    seg_en_d = seg_en_q;
    cnt_d    = cnt_q;
    if (dwellDone) begin
      if (en && !atTop) begin
        seg_en_d = (seg_en_q << 1) | N'(1);
        cnt_d    = delay;
      end else if (!en && !atBottom) begin
        seg_en_d = seg_en_q >> 1;
        cnt_d    = delay;
      end
    end else begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // A fresh request direction wins over settling when both apply in one cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StOff: begin
        if (en) state_d = StUp;
      end
      StUp: begin
        if (!en)                       state_d = StDown;
        else if (atTop && dwellDone)   state_d = StOn;
      end
      StOn: begin
        if (!en) state_d = StDown;
      end
      StDown: begin
        if (en)                          state_d = StUp;
        else if (atBottom && dwellDone)  state_d = StOff;
      end
      default: state_d = StOff;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= StOff;
      seg_en_q <= '0;
      cnt_q    <= '0;
      on_q     <= 1'b0;
      off_q    <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      seg_en_q <= seg_en_d;
      cnt_q    <= cnt_d;
      on_q     <= (state_d == StOn);
      off_q    <= (state_d == StOff);
      busy_q   <= (state_d == StUp) || (state_d == StDown);
    end
  end

  assign seg_en = seg_en_q;
  assign on     = on_q;
  assign off    = off_q;
  assign busy   = busy_q;

endmodule

// File: tb/tb_la_seqen.sv
// Directed-vector bench for la_seqen (N=4, CW=8) with hand-derived
// segment levels and flag timing for each scenario.
module tb_la_seqen;

   localparam int N  = 4;
   localparam int CW = 8;

   logic          clock;
   logic          reset;
   logic          en;
   logic [CW-1:0] delay;
   logic [N-1:0]  segEn;
   logic          onFlag;
   logic          offFlag;
   logic          busyFlag;

   int numVectors;
   int numMiscompares;

   la_seqen #(.N(N), .CW(CW), .PROP("DEFAULT")) dut (
      .clk    (clock),
      .reset  (reset),
      .en     (en),
      .delay  (delay),
      .seg_en (segEn),
      .on     (onFlag),
      .off    (offFlag),
      .busy   (busyFlag)
   );

   // Free-running clock, period 10.
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   // Thermometer code for a given segment level.
   function automatic logic [31:0] therm(input int level);
      logic [31:0] one;
      one = 32'd1;
      return (one << level) - 32'd1;
   endfunction

   // Advance one active edge and settle just after it.
   task automatic applyStimulus();
      @(posedge clock);
      #1;
   endtask

   // Single point of comparison: counts and reports mismatches.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      numVectors++;
      if (observed !== expected) begin
         numMiscompares++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at t=%0t",
                  tag, observed, expected, $time);
      end
   endtask

   // Main directed sequence.
   initial begin
      int lvl;
      numVectors     = 0;
      numMiscompares = 0;
      reset = 1'b1;
      en    = 1'b1;
      delay = 8'd2;

      for (int i = 0; i < 2; i++) begin
         applyStimulus();
         checkOutput("rst_seg",  32'(segEn),    32'h0);
         checkOutput("rst_off",  32'(offFlag),  32'd1);
         checkOutput("rst_on",   32'(onFlag),   32'd0);
         checkOutput("rst_busy", 32'(busyFlag), 32'd0);
      end
      en    = 1'b0;
      reset = 1'b0;
      applyStimulus();
      checkOutput("idle_off", 32'(offFlag), 32'd1);

      $display("[TB] full ramp up, delay=2");
      delay = 8'd2;
      en    = 1'b1;
      for (int k = 0; k <= 12; k++) begin
         applyStimulus();
         lvl = (k / 3 + 1 > 4) ? 4 : k / 3 + 1;
         checkOutput("up_seg",  32'(segEn),    therm(lvl));
         checkOutput("up_busy", 32'(busyFlag), (k < 12) ? 32'd1 : 32'd0);
         checkOutput("up_on",   32'(onFlag),   (k == 12) ? 32'd1 : 32'd0);
      end

      $display("[TB] ramp down, delay=2");
      en = 1'b0;
      for (int k = 0; k <= 12; k++) begin
         applyStimulus();
         lvl = (3 - k / 3 < 0) ? 0 : 3 - k / 3;
         checkOutput("dn_seg", 32'(segEn),   therm(lvl));
         checkOutput("dn_off", 32'(offFlag), (k == 12) ? 32'd1 : 32'd0);
         checkOutput("dn_on",  32'(onFlag),  32'd0);
      end

      $display("[TB] mid-ramp reversal, delay=3");
      delay = 8'd3;
      en    = 1'b1;
      for (int k = 0; k <= 16; k++) begin
         applyStimulus();
         if (k < 4)       lvl = 1;
         else if (k < 8)  lvl = 2;
         else if (k < 12) lvl = 1;
         else             lvl = 0;
         checkOutput("rev_seg", 32'(segEn),   therm(lvl));
         checkOutput("rev_off", 32'(offFlag), (k == 16) ? 32'd1 : 32'd0);
         en = (k + 1 < 5);
      end

      $display("[TB] delay=0 ramp, then delay=5 for the next ramp");
      delay = 8'd0;
      en    = 1'b1;
      for (int k = 0; k <= 4; k++) begin
         applyStimulus();
         lvl = (k + 1 > 4) ? 4 : k + 1;
         checkOutput("d0_seg",  32'(segEn),    therm(lvl));
         checkOutput("d0_on",   32'(onFlag),   (k == 4) ? 32'd1 : 32'd0);
         checkOutput("d0_busy", 32'(busyFlag), (k < 4) ? 32'd1 : 32'd0);
      end
      delay = 8'd5;
      applyStimulus();
      applyStimulus();
      checkOutput("d5_hold", 32'(segEn), therm(4));
      en = 1'b0;
      for (int k = 0; k <= 24; k++) begin
         applyStimulus();
         lvl = (3 - k / 6 < 0) ? 0 : 3 - k / 6;
         checkOutput("d5_seg", 32'(segEn),   therm(lvl));
         checkOutput("d5_off", 32'(offFlag), (k == 24) ? 32'd1 : 32'd0);
      end

      $display("[TB] reset mid-ramp, then fast en toggling, delay=4");
      delay = 8'd4;
      en    = 1'b1;
      for (int k = 0; k <= 5; k++) applyStimulus();
      checkOutput("mr_pre", 32'(segEn), therm(2));
      reset = 1'b1;
      applyStimulus();
      checkOutput("mr_seg",  32'(segEn),    32'h0);
      checkOutput("mr_off",  32'(offFlag),  32'd1);
      checkOutput("mr_busy", 32'(busyFlag), 32'd0);
      reset = 1'b0;
      en    = 1'b0;
      applyStimulus();
      checkOutput("mr_idle", 32'(segEn), 32'h0);
      for (int i = 0; i < 30; i++) begin
         en = (i % 2 == 0);
         applyStimulus();
         lvl = ((i / 5) % 2 == 0) ? 1 : 0;
         checkOutput("tog_seg", 32'(segEn), therm(lvl));
      end

      $display("== %0d vectors applied, %0d miscompares ==", numVectors, numMiscompares);
      $finish;
   end

endmodule

// File: doc/la_seqen.md
# la_seqen

Staged enable sequencer for a chain of buffered enable segments (power-switch or drive-strength buffer groups). Turns segments on one at a time in ascending order, and off in descending order, with a programmable dwell between steps to limit inrush and simultaneous-switching current. It sits between a single block-level enable request and the per-segment buffer enables.

## Interface

**Parameters**
- `N`, default 4: number of enable segments (≥1).
- `CW`, default 8: dwell counter width.
- `PROP`, default "DEFAULT": implementation property string; no functional effect.

**Ports**
- `clk` input, 1: clock.
- `reset` input, 1: reset. Synchronous and active-high. One clock domain.
- `en` input, 1: target request. 1 means all segments on; 0 means all segments off.
- `delay` input, CW: dwell between steps. The step period is `delay+1` cycles.
- `seg_en` output, N: segment enables, thermometer coded (bit 0 first on, last off).
- `on` output, 1: all segments on and dwell expired.
- `off` output, 1: all segments off and dwell expired.
- `busy` output, 1: sequencing in progress; equals `!(on|off)`.

## Operation

**State**
- `seg_en` register, thermometer code; its level is L = number of set bits, 0..N.
- Dwell counter `cnt`, CW bits.
- FSM state: OFF, UP, ON, DOWN.

**Step rule**, evaluated every edge when not in reset:
- A step occurs when `cnt==0` and L ≠ target, where target = `en ? N : 0`.
- Step up: set bit L. Step down: clear bit L−1.
- On a step, `cnt <= delay`. `delay` is sampled only at that edge, so a mid-dwell change affects the next dwell only.
- With no step: if `cnt!=0` then `cnt <= cnt-1`. Otherwise `cnt` holds at 0.

**FSM transitions**
- OFF → UP when `en=1`.
- UP → ON when L==N and `cnt==0`.
- UP → DOWN when `en=0`.
- ON → DOWN when `en=0`.
- DOWN → OFF when L==0 and `cnt==0`.
- DOWN → UP when `en=1`.

**Flags**
- `on=1` only in ON. `off=1` only in OFF. `busy=1` in UP or DOWN.
- All three flags are registered and update on the same edge as the state.

**Boundary conditions**
- **Direction reversal mid-ramp:** the dwell in progress is not restarted. The next step, taken when `cnt` reaches 0, goes in the new direction. No segment is skipped or double-toggled.
- **Reversal exactly on a step edge:** the step direction uses the `en` value sampled at that edge.
- **`en` toggling faster than the step period:** at most one segment changes per `delay+1` cycles.
- **Reaching L==N or L==0:** a final dwell of `delay+1` cycles is still served before `on`/`off` asserts.
- **`delay=0`:** one segment per cycle.
- **`delay` at maximum (all ones):** `2^CW` cycles per step. The counter never wraps.
- **Reset mid-ramp:** on the next edge all of `seg_en` clears at once, with `cnt=0` and state OFF. This abrupt off is accepted.
- **N=1:** degenerates to a single enable with a turn-on/turn-off settle delay.

## Timing

- **Reset values:** `seg_en=0`, `cnt=0`, state OFF, `on=0`, `off=1`, `busy=0`.
- **Turn-on from settled OFF:** with `en` sampled high at edge E, `seg_en[0]` rises at E (zero dwell on first step). Each bit k rises at E+k·(`delay`+1). `on` rises at E+N·(`delay`+1).
- **Turn-off from settled ON:** symmetric. With `en` sampled low at edge E, `seg_en[N-1]` falls at E. `off` rises at E+N·(`delay`+1).
- **Flag timing:** `on`/`off` fall on the same edge as the first step away from the settled level.
- **Output registration:** no combinational path from `en` or `delay` to any output.

## Test plan

1. **Reset.** Assert `reset` for 2 cycles with `en=1`. Required: `seg_en=0000`, `off=1`, `on=0`, `busy=0`, and no segment rises while `reset=1`.
2. **Full ramp up.** N=4, `delay=2`, `en` 0→1 sampled at E. Required: `seg_en`=0001@E, 0011@E+3, 0111@E+6, 1111@E+9, and `on`=1@E+12 with `busy`=1 over E..E+11.
3. **Ramp down.** From settled ON with `delay=2`, drop `en` at E. Required: `seg_en`=0111@E, 0011@E+3, 0001@E+6, 0000@E+9, and `off`=1@E+12.
4. **Mid-ramp reversal.** `delay=3`, `en` rises at E, then falls one cycle after the second step. Required: 0001@E, 0011@E+4, 0001@E+8, 0000@E+12, `off`@E+16, and never 0111.
5. **`delay=0` with a `delay` change.** Required: one segment per cycle, so 1111 three edges after 0001. Then set `delay=5` during the ON dwell; only the next ramp uses period 6.
6. **Reset during ramp, then glitch filter.** Assert `reset` while `seg_en=0011`. Required: 0000 on the next edge and `off=1`. Then toggle `en` every cycle with `delay=4`. Required: `seg_en` changes at most once per 5 cycles and L stays in {0,1}.
